// File: rtl/zap_shift_operand_stage_pkg.sv
// zap_shift_operand_stage_pkg: shift-type encodings shared with the shifter, the request tuple, and ARM shift canonicalisation.
package zap_shift_operand_stage_pkg;

    localparam int N_SHIFT_OPS = 5;
    localparam int TW = $clog2(N_SHIFT_OPS);

    localparam logic [TW-1:0] LSL     = 3'd0;
    localparam logic [TW-1:0] LSR     = 3'd1;
    localparam logic [TW-1:0] ASR     = 3'd2;
    localparam logic [TW-1:0] ROR     = 3'd3;
    localparam logic [TW-1:0] RORI    = 3'd4;
    localparam logic [TW-1:0] ROR_1   = 3'd5;
    localparam logic [TW-1:0] RRC     = 3'd6;
    localparam logic [TW-1:0] LSL_SAT = 3'd7;

    typedef struct packed {
        logic [31:0]   source;
        logic [7:0]    amount;
        logic          carry;
        logic [TW-1:0] shift_type;
    } shift_req_t;

    // Immediate #0 encodes LSR/ASR #32 and RRX; register amounts pass through for the shifter to resolve.
    function automatic shift_req_t canonicalise(
        input logic [31:0] source,
        input logic        carry,
        input logic [1:0]  kind,
        input logic        reg_shift,
        input logic [4:0]  imm,
        input logic        sat,
        input logic [7:0]  rs
    );
        shift_req_t r;
        logic       imm_zero;
        imm_zero     = (imm == 5'd0);
        r.source     = source;
        r.carry      = carry;
        r.shift_type = sat ? LSL_SAT :
                       reg_shift ? {1'b0, kind} :
                       (kind == 2'd3) ? (imm_zero ? RRC : RORI) : {1'b0, kind};
        r.amount     = sat ? 8'd1 :
                       reg_shift ? rs :
                       (imm_zero && (kind == 2'd1 || kind == 2'd2)) ? 8'd32 : {3'd0, imm};
        return r;
    endfunction

endpackage

// File: rtl/zap_shift_skid_queue.sv
// zap_shift_skid_queue: 2-entry FIFO of shift requests with flush; the head register holds while stalled.
module zap_shift_skid_queue
    import zap_shift_operand_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_flush,
    input  logic       i_push,
    input  shift_req_t i_data,
    input  logic       i_pop,
    output shift_req_t o_head,
    output logic       o_valid,
    output logic       o_full
);

    shift_req_t r_q0;
    shift_req_t r_q1;
    logic [1:0] r_count;
    logic       w_pop;

    assign w_pop   = i_pop && (r_count != 2'd0);
    assign o_head  = r_q0;
    assign o_valid = (r_count != 2'd0);
    assign o_full  = (r_count == 2'(DEPTH));

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_q0    <= '0;
            r_q1    <= '0;
            r_count <= 2'd0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            if (w_pop && r_count == 2'd2)
                r_q0 <= r_q1;
            if (i_push) begin
                if (r_count == 2'd0 || (w_pop && r_count == 2'd1))
                    r_q0 <= i_data;
                else
                    r_q1 <= i_data;
            end
            r_count <= r_count + 2'(i_push) - 2'(w_pop);
        end
    end

endmodule

// File: rtl/zap_shift_operand_stage.sv
// zap_shift_operand_stage: canonicalises ARM shift requests and queues them for the barrel shifter,
// waiting for a late Rs operand on register-specified shifts.
module zap_shift_operand_stage
    import zap_shift_operand_stage_pkg::*;
#(
    parameter int SHIFT_OPS = 5,
    parameter int QDEPTH    = 2
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic                         i_flush,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [31:0]                  i_source,
    input  logic                         i_carry,
    input  logic [1:0]                   i_shift_kind,
    input  logic                         i_reg_shift,
    input  logic [4:0]                   i_imm_amount,
    input  logic                         i_sat,
    input  logic [7:0]                   i_rs_data,
    input  logic                         i_rs_valid,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [31:0]                  o_source,
    output logic [7:0]                   o_amount,
    output logic                         o_carry,
    output logic [$clog2(SHIFT_OPS)-1:0] o_shift_type
);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_WAIT_RS = 1'b1;

    logic [0:0]  r_state;
    logic [31:0] r_source;
    logic        r_carry;
    logic [1:0]  r_kind;
    logic        r_sat;
    logic [7:0]  r_rs;
    logic        r_rs_got;
    logic        w_full;
    logic        w_accept;
    logic        w_direct;
    logic        w_resume;
    logic        w_push;
    shift_req_t  w_data;
    shift_req_t  w_head;

    assign o_ready  = (r_state == S_IDLE) && !w_full;
    assign w_accept = i_valid && o_ready;
    assign w_direct = w_accept && (!i_reg_shift || i_rs_valid);
    assign w_resume = (r_state == S_WAIT_RS) && !w_full && (r_rs_got || i_rs_valid);
    assign w_push   = (w_direct || w_resume) && !i_flush;

    // Once Rs has been captured while waiting, it takes precedence over later i_rs_data.
    assign w_data = (r_state == S_WAIT_RS) ?
        canonicalise(r_source, r_carry, r_kind, 1'b1, 5'd0, r_sat, r_rs_got ? r_rs : i_rs_data) :
        canonicalise(i_source, i_carry, i_shift_kind, i_reg_shift, i_imm_amount, i_sat, i_rs_data);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n || i_flush) begin
            r_state  <= S_IDLE;
            r_rs_got <= 1'b0;
        end else if (w_accept && !w_direct) begin
            r_state  <= S_WAIT_RS;
            r_source <= i_source;
            r_carry  <= i_carry;
            r_kind   <= i_shift_kind;
            r_sat    <= i_sat;
            r_rs_got <= 1'b0;
        end else if (w_resume) begin
            r_state  <= S_IDLE;
        end else if (r_state == S_WAIT_RS && i_rs_valid && !r_rs_got) begin
            r_rs     <= i_rs_data;
            r_rs_got <= 1'b1;
        end
    end

    zap_shift_skid_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_flush   (i_flush),
        .i_push    (w_push),
        .i_data    (w_data),
        .i_pop     (i_ready),
        .o_head    (w_head),
        .o_valid   (o_valid),
        .o_full    (w_full)
    );

    assign o_source     = w_head.source;
    assign o_amount     = w_head.amount;
    assign o_carry      = w_head.carry;
    assign o_shift_type = w_head.shift_type;

endmodule

// File: tb/tb_zap_shift_operand_stage.sv
// tb_zap_shift_operand_stage: directed and random stimulus checked against a queue-based reference model.
module tb_zap_shift_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, valid, carry, reg_s, sat, rs_valid, ready;
    logic [31:0] src;
    logic [1:0]  kind;
    logic [4:0]  imm;
    logic [7:0]  rs;
    logic        o_ready, o_valid, o_carry;
    logic [31:0] o_source;
    logic [7:0]  o_amount;
    logic [2:0]  o_type;

    typedef struct {
        logic [31:0] s;
        logic [7:0]  a;
        logic        c;
        logic [2:0]  t;
    } mreq_t;

    mreq_t       m_q[$];
    bit          m_wait, m_got;
    logic [31:0] p_s;
    logic        p_c, p_sat;
    logic [1:0]  p_k;
    logic [7:0]  m_rs;
    int          n_vec, n_err;

    always #5 clk = ~clk;

    zap_shift_operand_stage dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_flush      (flush),
        .i_valid      (valid),
        .o_ready      (o_ready),
        .i_source     (src),
        .i_carry      (carry),
        .i_shift_kind (kind),
        .i_reg_shift  (reg_s),
        .i_imm_amount (imm),
        .i_sat        (sat),
        .i_rs_data    (rs),
        .i_rs_valid   (rs_valid),
        .o_valid      (o_valid),
        .i_ready      (ready),
        .o_source     (o_source),
        .o_amount     (o_amount),
        .o_carry      (o_carry),
        .o_shift_type (o_type)
    );

    // Type codes: LSL 0, LSR 1, ASR 2, ROR 3, RORI 4, RRC 6, LSL_SAT 7.
    function automatic mreq_t mcanon(logic [31:0] s, logic c, logic [1:0] k, logic rg,
                                     logic [4:0] n, logic st, logic [7:0] r);
        mreq_t q;
        q.s = s;
        q.c = c;
        if (st) begin
            q.t = 3'd7; q.a = 8'd1;
        end else if (rg) begin
            q.t = {1'b0, k}; q.a = r;
        end else if (k == 2'd3) begin
            q.t = (n == 5'd0) ? 3'd6 : 3'd4; q.a = {3'd0, n};
        end else begin
            q.t = {1'b0, k}; q.a = (n == 5'd0 && k != 2'd0) ? 8'd32 : {3'd0, n};
        end
        return q;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check();
        chk("o_valid", 64'(o_valid), 64'(m_q.size() > 0));
        chk("o_ready", 64'(o_ready), 64'(!m_wait && m_q.size() < 2));
        if (m_q.size() > 0)
            chk("head", 64'({o_source, o_amount, o_carry, o_type}),
                64'({m_q[0].s, m_q[0].a, m_q[0].c, m_q[0].t}));
    endtask

    task automatic model_step();
        int    sz = m_q.size();
        bit    rdy = !m_wait && sz < 2;
        bit    pop = sz > 0 && ready;
        bit    push = 1'b0;
        mreq_t it;
        if (!rst_n || flush) begin
            m_q.delete();
            m_wait = 1'b0;
            m_got  = 1'b0;
            return;
        end
        if (rdy && valid) begin
            if (!reg_s || rs_valid) begin
                push = 1'b1;
                it   = mcanon(src, carry, kind, reg_s, imm, sat, rs);
            end else begin
                m_wait = 1'b1; m_got = 1'b0;
                p_s = src; p_c = carry; p_k = kind; p_sat = sat;
            end
        end else if (m_wait) begin
            if (sz < 2 && (m_got || rs_valid)) begin
                push   = 1'b1;
                it     = mcanon(p_s, p_c, p_k, 1'b1, 5'd0, p_sat, m_got ? m_rs : rs);
                m_wait = 1'b0;
            end else if (rs_valid && !m_got) begin
                m_got = 1'b1;
                m_rs  = rs;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back(it);
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check();
    endtask

    task automatic idle();
        valid = 0; flush = 0; sat = 0; reg_s = 0; rs_valid = 0; ready = 1; rst_n = 1;
    endtask

    task automatic drain();
        idle();
        repeat (3) cyc();
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        idle();
        rst_n = 0; src = 32'hDEAD_BEEF; carry = 1; kind = 2'd2; imm = 5'd9; rs = 8'h55;
        cyc(); cyc();
        chk("rst_outs", 64'({o_valid, o_source, o_amount, o_carry, o_type}), 64'(0));
        chk("rst_ready", 64'(o_ready), 64'(1));
        rst_n = 1;

        valid = 1; src = 32'h8000_0001; carry = 0; kind = 2'd1; imm = 5'd0;
        cyc();
        chk("lsr0_valid", 64'(o_valid), 64'(1));
        chk("lsr0_type", 64'(o_type), 64'(1));
        chk("lsr0_amt", 64'(o_amount), 64'(32));
        chk("lsr0_src", 64'(o_source), 64'(32'h8000_0001));

        kind = 2'd3; imm = 5'd0; carry = 1;
        cyc();
        chk("rrc_type", 64'(o_type), 64'(6));
        chk("rrc_amt", 64'(o_amount), 64'(0));
        chk("rrc_carry", 64'(o_carry), 64'(1));
        imm = 5'd4;
        cyc();
        chk("rori_type", 64'(o_type), 64'(4));
        chk("rori_amt", 64'(o_amount), 64'(4));
        valid = 0;
        cyc();

        valid = 1; reg_s = 1; kind = 2'd0; rs_valid = 0; src = 32'h0000_00F0;
        cyc();
        valid = 0;
        chk("wait_ready0", 64'(o_ready), 64'(0));
        cyc();
        chk("wait_ready1", 64'(o_ready), 64'(0));
        cyc();
        chk("wait_ready2", 64'(o_ready), 64'(0));
        rs_valid = 1; rs = 8'h21;
        cyc();
        rs_valid = 0; reg_s = 0;
        chk("rs_valid_out", 64'(o_valid), 64'(1));
        chk("rs_amt", 64'(o_amount), 64'(8'h21));
        chk("rs_type", 64'(o_type), 64'(0));

        drain();
        ready = 0; valid = 1; kind = 2'd0; src = 32'h1111_0001; imm = 5'd3;
        cyc();
        src = 32'h2222_0002; imm = 5'd5;
        cyc();
        chk("full_ready", 64'(o_ready), 64'(0));
        src = 32'h3333_0003; imm = 5'd9;
        cyc();
        chk("stall_src", 64'(o_source), 64'(32'h1111_0001));
        chk("stall_amt", 64'(o_amount), 64'(3));
        valid = 0; ready = 1;
        cyc();
        chk("drain_src", 64'(o_source), 64'(32'h2222_0002));
        cyc();
        chk("drain_empty", 64'(o_valid), 64'(0));

        valid = 1; sat = 1; kind = 2'd2; imm = 5'd7;
        cyc();
        sat = 0; valid = 0;
        chk("sat_type", 64'(o_type), 64'(7));
        chk("sat_amt", 64'(o_amount), 64'(1));

        drain();
        ready = 0; valid = 1; kind = 2'd1; imm = 5'd2;
        cyc();
        reg_s = 1; rs_valid = 0;
        cyc();
        valid = 0; reg_s = 0;
        chk("pre_flush_ready", 64'(o_ready), 64'(0));
        flush = 1; valid = 1;
        cyc();
        flush = 0; valid = 0;
        chk("flush_valid", 64'(o_valid), 64'(0));
        chk("flush_ready", 64'(o_ready), 64'(1));

        ready = 0; valid = 1; imm = 5'd6; src = 32'hCAFE_F00D; carry = 1;
        cyc(); cyc();
        rst_n = 0;
        cyc();
        rst_n = 1; valid = 0;
        chk("midrst_outs", 64'({o_valid, o_source, o_amount, o_carry, o_type}), 64'(0));

        for (int i = 0; i < 3000; i++) begin
            rst_n    = ($urandom_range(99) != 0);
            flush    = ($urandom_range(99) < 3);
            valid    = $urandom_range(1);
            reg_s    = ($urandom_range(9) < 4);
            rs_valid = ($urandom_range(9) < 4);
            sat      = ($urandom_range(9) == 0);
            ready    = ($urandom_range(9) < 6);
            carry    = $urandom_range(1);
            kind     = 2'($urandom_range(3));
            imm      = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
            rs       = 8'($urandom);
            src      = $urandom;
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
